inv_shift_sub_unit: RTL
=======================

INV_SHIFT_SUB_UNIT -- requirements
Module: inv_shift_sub_unit

Interface
REQ-001 SHALL have parameter: LANES, default 1, bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  in_data holds a valid 128-bit AES state.
REQ-005 SHALL have port: in_ready  output  1  block can accept a state this cycle.
REQ-006 SHALL have port: in_data  input  128  input state; byte k = in_data[127-8k -: 8], with s[r,c] = byte 4c+r (FIPS-197 column-major).
REQ-007 SHALL have port: out_valid  output  1  out_data holds a finished result.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts the result this cycle.
REQ-009 SHALL have port: out_data  output  128  InvSubBytes(InvShiftRows(in_data)), same byte ordering.

Function
REQ-010 SHALL implement states IDLE, BUSY, DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE; in_valid is ignored in BUSY and DONE.
REQ-012 SHALL accept in IDLE when in_valid=1: latch InvShiftRows(in_data), clear group counter, go to BUSY.
REQ-013 SHALL use InvShiftRows mapping: output s'[r,c] = s[r,(c-r) mod 4].
REQ-014 SHALL, on each BUSY edge, replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register with their inverse S-box values, then increment cnt.
REQ-015 SHALL go to DONE on the edge that processes group 16/LANES-1; cnt wraps to 0.
REQ-016 SHALL assert out_valid exactly 16/LANES edges after the accepting edge (16 for LANES=1; 1 for LANES=16).
REQ-017 SHALL assert out_valid=1 only in DONE.
REQ-018 SHALL hold out_data and out_valid stable in DONE while out_ready=0, for any number of cycles.
REQ-019 SHALL return to IDLE on the DONE edge where out_ready=1; the next accept is possible one edge later.
REQ-020 SHALL drive out_data to 128'h0 whenever out_valid=0.
REQ-021 SHALL ignore out_ready outside DONE.
REQ-022 SHALL ignore in_valid/in_data changes during BUSY; the latched state is unaffected.
REQ-023 SHALL sustain throughput of one block per 16/LANES+2 cycles with in_valid and out_ready held high.

Reset
REQ-024 SHALL, when rst=1 at an edge, force IDLE, cnt=0, working register=0, in_ready=1, out_valid=0, out_data=0, from any state.
REQ-025 SHALL discard a partially processed or unconsumed block on reset.
REQ-026 SHALL give rst priority over in_valid and out_ready in the same cycle.

Structure
REQ-027 SHALL take the state width (128), FSM state encodings and the byte-index helper from the shared AES definitions include.
REQ-028 SHALL instantiate the existing inverse S-box module LANES times as the only sub-modules, one per lane, fed from the cnt-selected bytes.
REQ-029 SHALL contain no other lookup tables.

Verification
REQ-030 SHALL test FIPS-197 C.1 round 1: in_data=7ad5fda789ef4e272bca100b3d9ff59f -> out_data=bd6e7c3df2b5779e0b61216e8b10b689, out_valid exactly 16 edges after accept (LANES=1).
REQ-031 SHALL test in_data=all 0x63 -> out_data=0; then in_data=0 -> out_data=all 0x52; for LANES=1, 4 and 16, with latencies 16, 4 and 1.
REQ-032 SHALL test backpressure: out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 SHALL test in_data toggled during BUSY -> result matches the first-accepted state only.
REQ-034 SHALL test rst=1 at BUSY cnt=7 -> next cycle in_ready=1, out_valid=0, out_data=0; a fresh block then completes correctly.
REQ-035 SHALL test back-to-back blocks with in_valid and out_ready held high -> accepts every 18 cycles (LANES=1); every result matches a reference model.

Source files
------------

// File: rtl/inv_shift_sub_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inv_shift_sub_unit_pkg
// Description : Shared AES definitions for the inverse ShiftRows/SubBytes
//               unit: state width, FSM encodings and byte-position helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package inv_shift_sub_unit_pkg;

    localparam int c_STATE_W = 128;

    // FSM encodings
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    // Bit position of the LSB of state byte k (byte 0 sits in bits 127:120).
    function automatic logic [6:0] byte_lsb(input logic [3:0] k);
        return 7'd120 - {k, 3'b000};
    endfunction

    // InvShiftRows: s'[r,c] = s[r,(c-r) mod 4], with s[r,c] = byte 4c+r.
    function automatic logic [c_STATE_W-1:0] inv_shift_rows(input logic [c_STATE_W-1:0] s);
        logic [c_STATE_W-1:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[byte_lsb(4'(4 * c + r)) +: 8] =
                    s[byte_lsb(4'(4 * ((c - r + 4) % 4) + r)) +: 8];
            end
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_shift_sub_unit_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module      : inv_shift_sub_unit_inv_sbox
// Description : Combinational AES inverse S-box, one byte in, one byte out.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_shift_sub_unit_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 is the leftmost byte of the literal.
    localparam logic [0:255][7:0] c_INV_SBOX = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
    };

    assign o_byte = c_INV_SBOX[i_byte];

endmodule
`default_nettype wire

// File: rtl/inv_shift_sub_unit.sv
`default_nettype none
// ============================================================================
// Module      : inv_shift_sub_unit
// Description : AES InvSubBytes(InvShiftRows(state)). The row shift is applied
//               when the state is latched; the byte substitution then runs
//               LANES bytes per cycle through LANES inverse S-box instances.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_shift_sub_unit
    import inv_shift_sub_unit_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [c_STATE_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [c_STATE_W-1:0] out_data
);

    // Index of the final byte group; with LANES=16 there is a single group.
    localparam logic [3:0] c_LAST = 4'(16 / LANES - 1);

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [c_STATE_W-1:0] r_work;

    logic [3:0] w_idx [LANES];
    logic [7:0] w_sub [LANES];

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_idx[l] = 4'(32'(r_cnt) * LANES + l);

            inv_shift_sub_unit_inv_sbox u_inv_sbox (
                .i_byte (r_work[byte_lsb(w_idx[l]) +: 8]),
                .o_byte (w_sub[l])
            );
        end
    endgenerate

    // FSM: latch shifted state, substitute one byte group per cycle, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
            r_work  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        r_work  <= inv_shift_rows(in_data);
                        r_cnt   <= 4'd0;
                        r_state <= c_S_BUSY;
                    end
                end
                c_S_BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_work[byte_lsb(w_idx[l]) +: 8] <= w_sub[l];
                    end
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= 4'd0;
                        r_state <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_S_DONE: begin
                    if (out_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_S_IDLE);
    assign out_valid = (r_state == c_S_DONE);
    // Result bus is forced to zero whenever no result is being presented.
    assign out_data  = out_valid ? r_work : '0;

endmodule
`default_nettype wire
